// File: rtl/rr_sel_arb2.sv
// Two-requester round-robin arbiter driving the mux2_1 select line.
// Bursts are capped at HOLD_MAX cycles whenever the other side is waiting.
module rr_sel_arb2 #(
    parameter int HOLD_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic last0,
    input  logic last1,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic busy
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          prio, prio_n;
    logic          s_q, s_n;
    logic [CW-1:0] cnt, cnt_n;

    logic own_req, own_last, oth_req, at_max, leave;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            s_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            s_q   <= s_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        oth_req  = 1'b0;
        unique case (state)
            OWN0: begin
                own_req  = req0;
                own_last = last0;
                oth_req  = req1;
            end
            OWN1: begin
                own_req  = req1;
                own_last = last1;
                oth_req  = req0;
            end
            default: ;
        endcase
    end

    assign at_max = (cnt == CMAX);
    assign leave  = !own_req || own_last || (at_max && oth_req);

    always_comb begin
        state_n = state;
        prio_n  = prio;
        s_n     = s_q;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (req0 && (!req1 || !prio)) begin
                    state_n = OWN0;
                    s_n     = 1'b0;
                end else if (req1) begin
                    state_n = OWN1;
                    s_n     = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (leave) begin
                    // Exit always hands priority to the other source.
                    prio_n = (state == OWN0);
                    cnt_n  = '0;
                    if (oth_req) begin
                        state_n = (state == OWN0) ? OWN1 : OWN0;
                        s_n     = (state == OWN0);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = at_max ? '0 : cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign busy = (state != IDLE);
    assign s    = s_q;

endmodule

// File: tb/tb_rr_sel_arb2.sv
// Bench for rr_sel_arb2: ownership model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_sel_arb2;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic last0 = 1'b0, last1 = 1'b0;
    logic gnt0, gnt1, s, busy;

    int tests = 0;
    int fails = 0;

    int m_owner = -1;
    int m_owned = 0;
    bit m_prio = 1'b0;
    bit m_s = 1'b0;
    bit run_cmp = 1'b0;

    rr_sel_arb2 #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .last0 (last0),
        .last1 (last1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .s     (s),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Ownership model: who owns, how many cycles owned, whose turn next.
    always @(posedge clk or negedge rst_n) begin
        int o, n, w;
        bit p, sv, mine, fin, oth;
        if (!rst_n) begin
            m_owner <= -1;
            m_owned <= 0;
            m_prio  <= 1'b0;
            m_s     <= 1'b0;
        end else begin
            o = m_owner; n = m_owned; p = m_prio; sv = m_s;
            if (o < 0) begin
                w = -1;
                if (req0 && req1) w = p ? 1 : 0;
                else if (req0) w = 0;
                else if (req1) w = 1;
                if (w >= 0) begin
                    o = w; n = 1; sv = (w == 1);
                end
            end else begin
                mine = (o == 0) ? req0 : req1;
                fin  = (o == 0) ? last0 : last1;
                oth  = (o == 0) ? req1 : req0;
                if (!mine || fin || (oth && (n % HOLD == 0))) begin
                    p = (o == 0);
                    if (oth) begin
                        o = 1 - o; n = 1; sv = (o == 1);
                    end else begin
                        o = -1;
                    end
                end else begin
                    n = n + 1;
                end
            end
            m_owner <= o;
            m_owned <= n;
            m_prio  <= p;
            m_s     <= sv;
        end
    end

    task automatic chk(string nm, logic got, logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_gnt0", gnt0, m_owner == 0);
            chk("m_gnt1", gnt1, m_owner == 1);
            chk("m_busy", busy, m_owner != -1);
            chk("m_s", s, m_s);
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_s", s, 1'b0);
        chk("rst_busy", busy, 1'b0);
        run_cmp = 1'b1;
        step(2);
        rst_n = 1'b1;

        // single source, last0 in third granted cycle
        req0 = 1'b1;
        step();
        chk("single_g1", gnt0, 1'b1);
        step();
        chk("single_g2", gnt0, 1'b1);
        step();
        chk("single_g3", gnt0, 1'b1);
        last0 = 1'b1;
        step();
        chk("single_end", gnt0, 1'b0);
        chk("single_busy", busy, 1'b0);
        chk("single_s", s, 1'b0);
        last0 = 1'b0;

        // both rise: source 1 favoured, then 4/4 alternation
        req1 = 1'b1;
        step();
        chk("fair_gnt1", gnt1, 1'b1);
        chk("fair_s", s, 1'b1);
        step(3);
        chk("cont_g1_4th", gnt1, 1'b1);
        step();
        chk("cont_g0_1st", gnt0, 1'b1);
        chk("cont_s0", s, 1'b0);
        step(3);
        chk("cont_g0_4th", gnt0, 1'b1);
        step();
        chk("cont_g1_again", gnt1, 1'b1);
        chk("cont_s1", s, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("cont_idle", busy, 1'b0);
        chk("cont_idle_s", s, 1'b1);

        // lone source 1 wraps past HOLD; stray last0 is ignored
        req1 = 1'b1;
        last0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wrap_gnt1", gnt1, 1'b1);
            chk("wrap_s", s, 1'b1);
        end
        req1 = 1'b0;
        last0 = 1'b0;
        step();
        chk("wrap_end", gnt1, 1'b0);
        chk("wrap_idle_s", s, 1'b1);

        // last0 coincides with preemption point
        req0 = 1'b1;
        step();
        chk("sim_g0", gnt0, 1'b1);
        step(3);
        chk("sim_g0_4th", gnt0, 1'b1);
        last0 = 1'b1;
        req1 = 1'b1;
        step();
        chk("sim_g1", gnt1, 1'b1);
        chk("sim_g0_off", gnt0, 1'b0);
        chk("sim_s", s, 1'b1);
        last0 = 1'b0;
        req0 = 1'b0;
        step();
        chk("sim_g1_hold", gnt1, 1'b1);
        chk("sim_s_hold", s, 1'b1);
        req1 = 1'b0;
        step();
        chk("sim_idle", busy, 1'b0);
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        chk("prio0_after", gnt0, 1'b1);

        // owner drops while other requests: direct hand-over
        req0 = 1'b0;
        step();
        chk("drop_raise", gnt1, 1'b1);
        chk("drop_raise_s", s, 1'b1);
        step();

        // async reset mid-OWN1
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt1", gnt1, 1'b0);
        chk("mid_rst_s", s, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        req0 = 1'b1;
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_gnt0", gnt0, 1'b1);
        chk("post_rst_gnt1", gnt1, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        step(3);

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
